ks10_mem_responder: RTL and testbench

Memory-side responder for the KS10 CPU backplane bus. It accepts memory read, write and read-pause-write (RPW) requests issued by the CPU's bus initiator. Each request is served against a synchronous single-port word-wide memory with a programmable number of wait states. The block returns a one-cycle acknowledge, plus read data where the cycle is a read. It never acknowledges I/O cycles or out-of-range addresses, so the initiator's existing non-existent-memory timeout logic handles those.

---
 rtl/ks10_mem_responder.sv | 132 +++++++++++++
 tb/tb_ks10_mem_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ks10_mem_responder.sv
// KS10 backplane memory responder: serves READ/WRITE/RPW requests against a
// single-port word memory with programmable wait states and a one-cycle ack.
module ks10_mem_responder #(
  parameter int unsigned ADDRW    = 19,
  parameter int unsigned MEMWORDS = 262144,
  parameter int unsigned WAITS    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             busREQI,
  input  logic [0:35]      busADDRI,
  input  logic [0:35]      busDATAI,
  output logic             busACKO,
  output logic [0:35]      busDATAO,
  output logic [ADDRW-1:0] memADDR,
  output logic [0:35]      memDIN,
  output logic             memWE,
  input  logic [0:35]      memDOUT
);

  typedef enum logic [2:0] {StIdle, StAccess, StAck, StDone, StLock} state_e;
  typedef enum logic [1:0] {CycRead, CycWrite, CycRpw} cyc_e;

  state_e      state_q, state_d;
  cyc_e        cyc_q, cyc_d;
  logic [21:0] addr_q, addr_d;
  logic [0:35] data_q, data_d;
  logic [3:0]  count_q, count_d;
  logic        lock_q, lock_d;
  logic [21:0] lock_addr_q, lock_addr_d;
  logic        ack_q, ack_d;
  logic [0:35] dout_q, dout_d;
  logic        we_q, we_d;
  logic [0:35] din_q, din_d;

  logic        req_rd, req_wr, req_io, in_range, req_valid, lock_hit;
  logic [21:0] req_addr;

  assign req_rd    = busADDRI[3];
  assign req_wr    = busADDRI[5];
  assign req_io    = busADDRI[10];
  assign req_addr  = busADDRI[14:35];
  assign in_range  = 32'(req_addr) < MEMWORDS;
  assign req_valid = busREQI & ~req_io & (req_rd | req_wr) & in_range;
  // Only a plain write back to the locked word may complete an RPW sequence.
  assign lock_hit  = req_valid & req_wr & ~req_rd & (req_addr == lock_addr_q);

  assign busACKO  = ack_q;
  assign busDATAO = dout_q;
  assign memADDR  = addr_q[ADDRW-1:0];
  assign memDIN   = din_q;
  assign memWE    = we_q;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    addr_d      = addr_q;
    data_d      = data_q;
    count_d     = count_q;
    lock_d      = lock_q;
    lock_addr_d = lock_addr_q;
    dout_d      = dout_q;
    din_d       = din_q;
    ack_d       = 1'b0;
    we_d        = 1'b0;

    unique case (state_q)
      StIdle, StLock: begin
        if ((state_q == StIdle) ? req_valid : lock_hit) begin
          addr_d  = req_addr;
          data_d  = busDATAI;
          cyc_d   = (req_rd && req_wr) ? CycRpw : (req_wr ? CycWrite : CycRead);
          count_d = 4'(WAITS);
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (count_q != 4'd0) begin
          count_d = count_q - 4'd1;
        end else begin
          if (cyc_q == CycWrite) begin
            we_d  = 1'b1;
            din_d = data_q;
          end else begin
            dout_d = memDOUT;
          end
          state_d = StAck;
        end
      end
      StAck: begin
        ack_d  = 1'b1;
        lock_d = (cyc_q == CycRpw);
        if (cyc_q == CycRpw) lock_addr_d = addr_q;
        state_d = StDone;
      end
      StDone: begin
        // Hold here until the initiator drops its request so it is served once.
        if (!busREQI) state_d = lock_q ? StLock : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cyc_q       <= CycRead;
      addr_q      <= '0;
      data_q      <= '0;
      count_q     <= '0;
      lock_q      <= 1'b0;
      lock_addr_q <= '0;
      ack_q       <= 1'b0;
      dout_q      <= '0;
      we_q        <= 1'b0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      count_q     <= count_d;
      lock_q      <= lock_d;
      lock_addr_q <= lock_addr_d;
      ack_q       <= ack_d;
      dout_q      <= dout_d;
      we_q        <= we_d;
      din_q       <= din_d;
    end
  end

endmodule

// File: tb/tb_ks10_mem_responder.sv
// Directed bench for ks10_mem_responder with WAITS=2, 5 and 0 instances.
module tb_ks10_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [0:35] addr_in = '0;
  logic [0:35] data_in = '0;
  logic req2 = 1'b0, req5 = 1'b0, req0 = 1'b0;

  logic ack2, ack5, ack0, mwe2, mwe5, mwe0;
  logic [0:35] dout2, dout5, dout0, mdin2, mdin5, mdin0, mdout2, mdout5, mdout0;
  logic [18:0] maddr2, maddr5, maddr0;

  int checks = 0;
  int errors = 0;
  int ack2_n = 0, we2_n = 0, ack5_n = 0, we5_n = 0;
  int unsigned last_at = 0;

  ks10_mem_responder #(.ADDRW(19), .MEMWORDS(262144), .WAITS(2)) u_w2 (
    .clk(clk), .rst(rst), .busREQI(req2), .busADDRI(addr_in), .busDATAI(data_in),
    .busACKO(ack2), .busDATAO(dout2), .memADDR(maddr2), .memDIN(mdin2), .memWE(mwe2),
    .memDOUT(mdout2));
  ks10_mem_responder #(.ADDRW(19), .MEMWORDS(262144), .WAITS(5)) u_w5 (
    .clk(clk), .rst(rst), .busREQI(req5), .busADDRI(addr_in), .busDATAI(data_in),
    .busACKO(ack5), .busDATAO(dout5), .memADDR(maddr5), .memDIN(mdin5), .memWE(mwe5),
    .memDOUT(mdout5));
  ks10_mem_responder #(.ADDRW(19), .MEMWORDS(262144), .WAITS(0)) u_w0 (
    .clk(clk), .rst(rst), .busREQI(req0), .busADDRI(addr_in), .busDATAI(data_in),
    .busACKO(ack0), .busDATAO(dout0), .memADDR(maddr0), .memDIN(mdin0), .memWE(mwe0),
    .memDOUT(mdout0));

  // Fixed address-derived content for the read-only instances.
  function automatic logic [0:35] pat(input logic [18:0] a);
    return {17'h0, a} ^ 36'o707070707070;
  endfunction

  logic [0:35] mem2 [0:1023];
  always @(posedge clk) if (mwe2) mem2[maddr2[9:0]] <= mdin2;
  assign mdout2 = mem2[maddr2[9:0]];
  assign mdout5 = pat(maddr5);
  assign mdout0 = pat(maddr0);

  always @(negedge clk) begin
    if (ack2) ack2_n++;
    if (mwe2) we2_n++;
    if (ack5) ack5_n++;
    if (mwe5) we5_n++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int s, input logic v);
    case (s)
      2: req2 = v;
      5: req5 = v;
      default: req0 = v;
    endcase
  endtask

  function automatic logic ack_of(input int s);
    case (s)
      2: return ack2;
      5: return ack5;
      default: return ack0;
    endcase
  endfunction

  // Raise a request, wait (bounded) for ack, optionally hold it, then drop it.
  // lat is measured from the sampling edge N.
  task automatic bus_cycle(input int s, input logic rd, input logic wr, input logic io,
                           input logic [21:0] a, input logic [0:35] d, input int budget,
                           input int hold, output logic got, output int unsigned lat);
    int unsigned issue;
    @(negedge clk);
    addr_in = '0;
    addr_in[3] = rd;
    addr_in[5] = wr;
    addr_in[10] = io;
    addr_in[14:35] = a;
    data_in = d;
    set_req(s, 1'b1);
    issue = cyc;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (ack_of(s)) begin
        got = 1'b1;
        lat = cyc - issue - 1;
        last_at = cyc;
      end
    end
    repeat (hold) @(negedge clk);
    set_req(s, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    logic got;
    int unsigned lat;
    int a0, w0;
    int unsigned at [4];
    logic [21:0] raddr [4];

    // Reset values
    #12;
    chk("rst_ack", ack2, 0);
    chk("rst_dout", dout2, 0);
    chk("rst_maddr", maddr2, 0);
    chk("rst_mdin", mdin2, 0);
    chk("rst_mwe", mwe2, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_no_ack", ack2_n, 0);

    // Write then read, WAITS=2
    w0 = we2_n;
    bus_cycle(2, 0, 1, 0, 22'o1234, 36'o123456701234, 30, 0, got, lat);
    chk("wr_ack", got, 1);
    chk("wr_lat", lat, 4);
    chk("wr_we_once", we2_n - w0, 1);
    bus_cycle(2, 1, 0, 0, 22'o1234, 36'o0, 30, 0, got, lat);
    chk("rd_ack", got, 1);
    chk("rd_lat", lat, 4);
    chk("rd_data", dout2, 36'o123456701234);

    // Invalid requests
    @(negedge clk);
    a0 = ack2_n;
    w0 = we2_n;
    bus_cycle(2, 1, 1, 1, 22'o1234, 36'o777, 64, 0, got, lat);
    chk("io_no_ack", got, 0);
    bus_cycle(2, 0, 1, 0, 22'o1000000, 36'o777, 64, 0, got, lat);
    chk("oor_no_ack", got, 0);
    chk("inv_no_we", we2_n - w0, 0);
    chk("inv_ack_cnt", ack2_n - a0, 0);

    // Held request acked once
    a0 = ack2_n;
    bus_cycle(2, 1, 0, 0, 22'o1234, 36'o0, 30, 20, got, lat);
    @(negedge clk);
    chk("held_one_ack", ack2_n - a0, 1);
    chk("held_data", dout2, 36'o123456701234);

    // RPW lock sequence
    bus_cycle(2, 0, 1, 0, 22'o100, 36'o111111111111, 30, 0, got, lat);
    chk("pre_wr100", got, 1);
    bus_cycle(2, 0, 1, 0, 22'o200, 36'o333333333333, 30, 0, got, lat);
    chk("pre_wr200", got, 1);
    bus_cycle(2, 1, 1, 0, 22'o100, 36'o555555555555, 30, 0, got, lat);
    chk("rpw_ack", got, 1);
    chk("rpw_lat", lat, 4);
    chk("rpw_data", dout2, 36'o111111111111);
    bus_cycle(2, 1, 0, 0, 22'o200, 36'o0, 40, 0, got, lat);
    chk("locked_rd_no_ack", got, 0);
    bus_cycle(2, 0, 1, 0, 22'o100, 36'o222222222222, 30, 0, got, lat);
    chk("unlock_wr_ack", got, 1);
    bus_cycle(2, 1, 0, 0, 22'o200, 36'o0, 30, 0, got, lat);
    chk("post_rd200_ack", got, 1);
    chk("post_rd200_data", dout2, 36'o333333333333);
    bus_cycle(2, 1, 0, 0, 22'o100, 36'o0, 30, 0, got, lat);
    chk("post_rd100_data", dout2, 36'o222222222222);

    // Reset mid-access, WAITS=5
    @(negedge clk);
    addr_in = '0;
    addr_in[5] = 1'b1;
    addr_in[14:35] = 22'o4321;
    data_in = 36'o666666666666;
    req5 = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_maddr", maddr5, 0);
    chk("mid_rst_dout2", dout2, 0);
    chk("mid_rst_mwe", mwe5, 0);
    chk("mid_rst_ack", ack5, 0);
    req5 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_rst_no_we", we5_n, 0);
    chk("mid_rst_no_ack", ack5_n, 0);
    bus_cycle(5, 1, 0, 0, 22'o4321, 36'o0, 40, 0, got, lat);
    chk("w5_rd_ack", got, 1);
    chk("w5_rd_lat", lat, 7);
    chk("w5_rd_data", dout5, pat(19'o4321));

    // WAITS=0 back-to-back reads
    raddr[0] = 22'o1;
    raddr[1] = 22'o2;
    raddr[2] = 22'o3;
    raddr[3] = 22'o777;
    for (int i = 0; i < 4; i++) begin
      bus_cycle(0, 1, 0, 0, raddr[i], 36'o0, 20, 0, got, lat);
      at[i] = last_at;
      chk("w0_ack", got, 1);
      chk("w0_lat", lat, 2);
      chk("w0_data", dout0, pat(raddr[i][18:0]));
    end
    for (int i = 1; i < 4; i++) chk("w0_spacing", at[i] - at[i-1], 4);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
